// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

  localparam int unsigned REG_IDX_W = 5;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/pipe_ctrl_load_use_detect.sv
// Combinational load-use hazard check between the EX load and the ID sources.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] idRs1,
  input  logic [REG_IDX_W-1:0] idRs2,
  input  logic                 idUsesRs2,
  input  logic [REG_IDX_W-1:0] exRd,
  input  logic                 exMemRead,
  input  logic                 exRegWrite,
  output logic                 hazard
);

  always_comb begin
    hazard = exMemRead && exRegWrite && (exRd != '0) &&
             ((exRd == idRs1) || (idUsesRs2 && (exRd == idRs2)));
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with multi-cycle unit handshake and timeout.
// Optional freeze-cycle counter enabled by defining PIPE_CTRL_STALL_CNT_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MC_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_mem_read,
  input  logic                 ex_reg_write,
  input  logic                 ex_mc,
  input  logic                 branch_taken,
  input  logic                 mc_done,
  output logic                 pc_en,
  output logic                 if_id_en,
  output logic                 id_ex_en,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 ex_mem_flush,
  output logic                 mc_start,
  output logic                 mc_err,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam int unsigned TO_W = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MC_TIMEOUT - 1);

  state_t          state, stateNext;
  logic [TO_W-1:0] toCnt, toCntNext;
  logic            errSet;
  logic            loadUse;

  load_use_detect uLoadUse (
    .idRs1      (id_rs1),
    .idRs2      (id_rs2),
    .idUsesRs2  (id_uses_rs2),
    .exRd       (ex_rd),
    .exMemRead  (ex_mem_read),
    .exRegWrite (ex_reg_write),
    .hazard     (loadUse)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      toCnt  <= '0;
      mc_err <= 1'b0;
    end else begin
      state <= stateNext;
      toCnt <= toCntNext;
      if (errSet) mc_err <= 1'b1;
    end
  end

  // Outputs are forced to the idle pattern while rst is high, whatever the inputs.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mc_start     = 1'b0;
    stateNext    = state;
    toCntNext    = toCnt;
    errSet       = 1'b0;
    if (!rst) begin
      case (state)
        RUN: begin
          if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (ex_mc) begin
            mc_start     = 1'b1;
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_flush = 1'b1;
            stateNext    = MC_WAIT;
            toCntNext    = '0;
          end else if (loadUse) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
        MC_WAIT: begin
          if (mc_done) begin
            stateNext = RUN;
          end else if (toCnt == TO_LAST) begin
            stateNext = RUN;
            errSet    = 1'b1;
          end else begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_flush = 1'b1;
            toCntNext    = toCnt + 1'b1;
          end
        end
        default: stateNext = RUN;
      endcase
    end
  end

`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [CNT_W-1:0] stallCnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stallCnt <= '0;
    end else if (!pc_en && (stallCnt != '1)) begin
      stallCnt <= stallCnt + 1'b1;
    end
  end

  assign stall_cnt = stallCnt;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MC_TIMEOUT, default 64, meaning max cycles to wait for mc_done before abort (range 2..1023).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of stall_cnt.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports id_rs1, id_rs2  input  5 each  source register fields of instruction in ID.
REQ-006 SHALL have port id_uses_rs2  input  1  ID instruction reads rs2.
REQ-007 SHALL have ports ex_rd  input  5, ex_mem_read  input  1, ex_reg_write  input  1  describing the instruction in EX.
REQ-008 SHALL have port ex_mc  input  1  EX instruction needs the multi-cycle unit (mul/div).
REQ-009 SHALL have port branch_taken  input  1  EX resolved a taken branch/jump.
REQ-010 SHALL have port mc_done  input  1  multi-cycle unit result valid, one-cycle pulse.
REQ-011 SHALL have outputs pc_en, if_id_en, id_ex_en  1 each  stage-register enables.
REQ-012 SHALL have outputs if_id_flush, id_ex_flush, ex_mem_flush  1 each  insert bubble into that register.
REQ-013 SHALL have outputs mc_start  1  one-cycle start pulse; mc_err  1  sticky timeout flag; stall_cnt  CNT_W  freeze-cycle counter.

Function
REQ-014 SHALL implement FSM states RUN and MC_WAIT; outputs are functions of state and current inputs (same-cycle).
REQ-015 In RUN with no event, all enables SHALL be 1 and all flushes 0.
REQ-016 Load-use hazard SHALL be: ex_mem_read & ex_reg_write & ex_rd!=0 & (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2)).
REQ-017 On load-use in RUN: pc_en=0, if_id_en=0, id_ex_flush=1, for exactly that cycle; no state change.
REQ-018 On branch_taken in RUN: if_id_flush=1, id_ex_flush=1, pc_en=1; branch_taken SHALL override load-use and ex_mc.
REQ-019 On ex_mc in RUN (no branch_taken): mc_start=1, pc_en=if_id_en=id_ex_en=0, ex_mem_flush=1, next state MC_WAIT, timeout counter cleared.
REQ-020 In MC_WAIT without mc_done: pc_en=if_id_en=id_ex_en=0, ex_mem_flush=1, timeout counter +1; load-use and branch_taken ignored.
REQ-021 In MC_WAIT with mc_done: all enables 1, ex_mem_flush=0, next state RUN.
REQ-022 If counter reaches MC_TIMEOUT-1 without mc_done: mc_err set (sticky until reset), outputs as REQ-021, next state RUN.
REQ-023 mc_done in RUN SHALL be ignored; mc_start SHALL never assert in MC_WAIT.

Reset
REQ-024 While rst=1: state RUN, timeout counter 0, mc_err 0, stall_cnt 0, outputs per REQ-015 with mc_start=0.
REQ-025 rst mid-MC_WAIT SHALL abandon the operation without setting mc_err.

Configuration
REQ-026 With PIPE_CTRL_STALL_CNT_EN defined, stall_cnt SHALL increment each cycle pc_en=0, saturating at all-ones.
REQ-027 Without PIPE_CTRL_STALL_CNT_EN, stall_cnt SHALL be constant 0 and no counter register exists.

Structure
REQ-028 Package pipe_ctrl_pkg SHALL hold the state enum (RUN, MC_WAIT) and register-index width constant (5).
REQ-029 Load-use compare (REQ-016) SHALL be sub-module load_use_detect, purely combinational.

Verification
REQ-030 ex_mem_read=1, ex_reg_write=1, ex_rd=5, id_rs1=5 -> one cycle pc_en=0, if_id_en=0, id_ex_flush=1; ex_rd=0 same case -> no stall.
REQ-031 id_uses_rs2=0, id_rs2=ex_rd=7, load in EX -> no stall; id_uses_rs2=1 -> stall.
REQ-032 branch_taken=1 with simultaneous load-use -> if_id_flush=id_ex_flush=1, pc_en=1.
REQ-033 ex_mc=1, mc_done after 5 cycles -> mc_start one pulse, 5 frozen cycles plus release cycle, state RUN, mc_err=0.
REQ-034 ex_mc=1, MC_TIMEOUT=4, no mc_done -> release after 4 cycles, mc_err=1 held until rst.
REQ-035 With PIPE_CTRL_STALL_CNT_EN, REQ-033 stimulus -> stall_cnt=6 (start cycle plus 5 wait); rst in MC_WAIT -> RUN, stall_cnt=0, mc_err=0.
